// File: rtl/inst_rom_loader.sv
// Writable instruction memory with a byte-stream boot loader; holds the core in reset until a load completes.
// Optional INST_ROM_INIT_EN: reset straight into RUN so a preloaded image runs immediately.
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned  WORDS     = 1 << DEPTH_LOG2;
  localparam logic [16:0] MAX_WORDS = 17'(WORDS);

  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, RUN} state_t;

`ifdef INST_ROM_INIT_EN
  localparam state_t RESET_STATE    = RUN;
  localparam logic   RESET_CORE_RST = 1'b0;
`else
  localparam state_t RESET_STATE    = IDLE;
  localparam logic   RESET_CORE_RST = 1'b1;
`endif

  state_t                  state, state_nxt;
  logic [7:0]              hdr_hi;
  logic [15:0]             rem;
  logic [1:0]              byte_cnt;
  logic [23:0]             word_buf;
  logic [DEPTH_LOG2-1:0]   wptr;
  logic [31:0]             mem [0:WORDS-1];

  logic        xfer;
  logic        word_we;
  logic [15:0] count_in;
  logic        overflow;

  assign xfer     = ld_valid && ld_ready;
  assign word_we  = (state == DATA) && xfer && (byte_cnt == 2'd3);
  assign count_in = {hdr_hi, ld_byte};
  assign overflow = {1'b0, count_in} > MAX_WORDS;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, RUN: if (ld_start) state_nxt = HDR_HI;
      HDR_HI:    if (xfer) state_nxt = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (count_in == 16'd0) state_nxt = RUN;
          else if (overflow)     state_nxt = IDLE;
          else                   state_nxt = DATA;
        end
      end
      DATA:      if (word_we && rem == 16'd1) state_nxt = RUN;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_STATE;
      core_rst <= RESET_CORE_RST;
      ld_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      hdr_hi   <= '0;
      rem      <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      wptr     <= '0;
    end else begin
      state    <= state_nxt;
      core_rst <= (state_nxt != RUN);
      ld_ready <= (state_nxt == HDR_HI) || (state_nxt == HDR_LO) || (state_nxt == DATA);
      busy     <= (state_nxt == HDR_HI) || (state_nxt == HDR_LO) || (state_nxt == DATA);
      done     <= ((state == HDR_LO) || (state == DATA)) && (state_nxt == RUN);
      unique case (state)
        IDLE, RUN: begin
          if (ld_start) begin
            err      <= 1'b0;
            wptr     <= '0;
            byte_cnt <= '0;
          end
        end
        HDR_HI: if (xfer) hdr_hi <= ld_byte;
        HDR_LO: begin
          if (xfer) begin
            rem <= count_in;
            if (count_in != 16'd0 && overflow) err <= 1'b1;
          end
        end
        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_buf <= {word_buf[15:0], ld_byte};
            if (byte_cnt == 2'd3) begin
              wptr <= wptr + 1'b1;
              rem  <= rem - 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the memory array has no reset; words survive a reset asserted mid-load.
  always_ff @(posedge clk) begin
    if (word_we) mem[wptr] <= {word_buf, ld_byte};
  end

  assign inst = (ce && state == RUN) ? mem[addr[DEPTH_LOG2+1:2]] : 32'd0;

  // Word-offset and above-depth address bits are deliberately dropped, so fetches wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed self-checking bench for inst_rom_loader (default DEPTH_LOG2=10).
// Build with INST_ROM_INIT_EN to check the preloaded reset state.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_start, ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        core_rst, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  inst_rom_loader #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_ready(ld_ready), .ce(ce), .addr(addr), .inst(inst),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one byte after 'gap' idle cycles, checking the handshake stays up during the gap.
  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      check("gap_ready", ld_ready, 1'b1);
      check("gap_busy", busy, 1'b1);
    end
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic start();
    @(negedge clk);
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  task automatic read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    ce   = 1'b1;
    addr = a;
    #1 check(tag, inst, exp);
  endtask

  initial begin
    reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00;
    ce = 1'b1; addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
`ifdef INST_ROM_INIT_EN
    check("rst_core_rst", core_rst, 1'b0);
`else
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_inst", inst, 32'd0);
`endif
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk) reset = 1'b0;

    // Basic load: two words, back-to-back bytes
    start();
    check("start_ready", ld_ready, 1'b1);
    check("start_busy", busy, 1'b1);
    check("start_core_rst", core_rst, 1'b1);
    send(8'h00, 0); send(8'h02, 0);
    send(8'h34, 0); send(8'h01, 0); send(8'h00, 0); send(8'h20, 0);
    send(8'h34, 0); send(8'h02, 0); send(8'hFF, 0);
    check("basic_no_early_done", done, 1'b0);
    check("basic_no_early_run", core_rst, 1'b1);
    send(8'hFF, 0);
    check("basic_done", done, 1'b1);
    check("basic_core_rst", core_rst, 1'b0);
    check("basic_ready_low", ld_ready, 1'b0);
    check("basic_busy_low", busy, 1'b0);
    @(posedge clk); #1;
    check("basic_done_pulse", done, 1'b0);
    read("basic_w0", 32'h0000_0000, 32'h3401_0020);
    read("basic_w1", 32'h0000_0004, 32'h3402_FFFF);
    read("low_bits_ignored", 32'h0000_0003, 32'h3401_0020);
    read("addr_wrap", 32'h0000_1004, 32'h3402_FFFF);
    @(negedge clk) ce = 1'b0;
    #1 check("ce_low_inst", inst, 32'd0);

    // Reload from RUN with 3-cycle gaps between every byte
    start();
    check("reload_core_rst", core_rst, 1'b1);
    check("reload_inst_off", inst, 32'd0);
    send(8'h00, 3); send(8'h02, 3);
    send(8'hDE, 3); send(8'hAD, 3); send(8'hBE, 3); send(8'hEF, 3);
    send(8'h01, 3); send(8'h23, 3); send(8'h45, 3); send(8'h67, 3);
    check("gaps_done", done, 1'b1);
    check("gaps_core_rst", core_rst, 1'b0);
    read("gaps_w0", 32'h0000_0000, 32'hDEAD_BEEF);
    read("gaps_w1", 32'h0000_0004, 32'h0123_4567);

    // Header overflow: 0x0401 words > 1024
    start();
    send(8'h04, 0); send(8'h01, 0);
    check("ovf_err", err, 1'b1);
    check("ovf_core_rst", core_rst, 1'b1);
    check("ovf_ready", ld_ready, 1'b0);
    check("ovf_busy", busy, 1'b0);
    check("ovf_no_done", done, 1'b0);
    read("ovf_idle_inst", 32'h0000_0000, 32'd0);
    @(posedge clk); #1;
    check("ovf_err_sticky", err, 1'b1);
    start();
    check("ovf_err_cleared", err, 1'b0);

    // Zero-length load from the session just started
    send(8'h00, 0); send(8'h00, 0);
    check("zero_done", done, 1'b1);
    check("zero_core_rst", core_rst, 1'b0);
    @(negedge clk) ce = 1'b0;
    #1 check("zero_ce_low", inst, 32'd0);
    read("zero_keeps_w0", 32'h0000_0000, 32'hDEAD_BEEF);

    // ld_start inside DATA is ignored, then reset mid-word
    start();
    send(8'h00, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, 0);
    start();
    check("data_start_busy", busy, 1'b1);
    check("data_start_ready", ld_ready, 1'b1);
    send(8'h33, 0); send(8'h44, 0); send(8'h55, 0);
    #2 reset = 1'b1;
    #1;
    check("async_core_rst", core_rst, 1'b1);
    check("async_ready", ld_ready, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_done", done, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", ld_ready, 1'b0);
    start();
    send(8'h00, 0); send(8'h00, 0);
    check("post_rst_done", done, 1'b1);
    read("midrst_w0", 32'h0000_0000, 32'h1122_3344);
    read("midrst_w1", 32'h0000_0004, 32'h0123_4567);
    read("midrst_wrap", 32'h0000_1000, 32'h1122_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
